// File: rtl/rtr_lar_pipe_pkg.sv
// Shared constants, width helpers and derived-width formulas for the
// lookahead-routing pipeline and its next-hop address sub-block.
package rtr_lar_pipe_pkg;

   localparam int CONNECTIVITY_LINE = 0;
   localparam int CONNECTIVITY_RING = 1;
   localparam int CONNECTIVITY_FULL = 2;

   localparam int ROUTING_TYPE_PHASED_DOR = 0;

   function automatic int clogb(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) result++;
      return result;
   endfunction

   function automatic int neighbors_per_dim(input int connectivity, input int k);
      return (connectivity == CONNECTIVITY_FULL) ? k - 1 : 2;
   endfunction

   function automatic int router_addr_width_of(input int k, input int dims);
      return dims * clogb(k);
   endfunction

   function automatic int dest_info_width_of(input int rcs, input int k, input int dims,
                                             input int nodes);
      return rcs * router_addr_width_of(k, dims) + clogb(nodes);
   endfunction

   function automatic int port_idx_width_of(input int connectivity, input int k, input int dims,
                                            input int nodes);
      return clogb(dims * neighbors_per_dim(connectivity, k) + nodes);
   endfunction

   function automatic int lar_info_width_of(input int rcs, input int connectivity, input int k,
                                            input int dims, input int nodes);
      return port_idx_width_of(connectivity, k, dims, nodes) + clogb(rcs);
   endfunction

endpackage

// File: rtl/rtr_next_hop_addr.sv
// Applies the hop named by an output port index to the current router address.
// Dimension 0 occupies the most significant digit; eject ports leave the address unchanged.
module rtr_next_hop_addr
   import rtr_lar_pipe_pkg::*;
#(
   parameter int num_routers_per_dim = 4,
   parameter int num_dimensions = 2,
   parameter int connectivity = CONNECTIVITY_LINE,
   parameter int port_idx_width = 3,
   localparam int dim_addr_width = clogb(num_routers_per_dim),
   localparam int router_addr_width = num_dimensions * dim_addr_width
)(
   input  logic [router_addr_width-1:0] router_address,
   input  logic [port_idx_width-1:0]    port_idx,
   output logic [router_addr_width-1:0] next_router_address
);

   localparam int num_neighbors = neighbors_per_dim(connectivity, num_routers_per_dim);
   localparam logic [dim_addr_width:0] k_ext = (dim_addr_width + 1)'(num_routers_per_dim);

   logic [dim_addr_width:0] digit_sum;

   // Down moves add k-1 so every step stays a modular add with one conditional subtract.
   always_comb begin
      next_router_address = router_address;
      digit_sum = '0;
      for (int d = 0; d < num_dimensions; d++) begin
         for (int j = 0; j < num_neighbors; j++) begin
            if (int'(port_idx) == d * num_neighbors + j) begin
               digit_sum = {1'b0, router_address[(num_dimensions-1-d)*dim_addr_width +: dim_addr_width]}
                         + (dim_addr_width + 1)'((connectivity == CONNECTIVITY_FULL) ? j + 1 :
                                                 ((j == 1) ? 1 : num_routers_per_dim - 1));
               if (digit_sum >= k_ext) digit_sum = digit_sum - k_ext;
               next_router_address[(num_dimensions-1-d)*dim_addr_width +: dim_addr_width] =
                  digit_sum[dim_addr_width-1:0];
            end
         end
      end
   end

endmodule

// File: rtl/rtr_lar_pipe.sv
// Two-stage lookahead route computation: stage 1 derives the next router address,
// stage 2 picks the phased dimension-order port and class the next router will use.
module rtr_lar_pipe
   import rtr_lar_pipe_pkg::*;
#(
   parameter int num_resource_classes = 2,
   parameter int num_routers_per_dim = 4,
   parameter int num_dimensions = 2,
   parameter int num_nodes_per_router = 1,
   parameter int connectivity = CONNECTIVITY_LINE,
   parameter int routing_type = ROUTING_TYPE_PHASED_DOR,
   localparam int router_addr_width = router_addr_width_of(num_routers_per_dim, num_dimensions),
   localparam int dest_info_width = dest_info_width_of(num_resource_classes, num_routers_per_dim,
                                                       num_dimensions, num_nodes_per_router),
   localparam int port_idx_width = port_idx_width_of(connectivity, num_routers_per_dim,
                                                     num_dimensions, num_nodes_per_router),
   localparam int lar_info_width = lar_info_width_of(num_resource_classes, connectivity,
                                                     num_routers_per_dim, num_dimensions,
                                                     num_nodes_per_router)
)(
   input  logic                         clk,
   input  logic                         reset,
   input  logic [router_addr_width-1:0] router_address,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [dest_info_width-1:0]   in_dest_info,
   input  logic [lar_info_width-1:0]    in_lar_info,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [dest_info_width-1:0]   out_dest_info,
   output logic [router_addr_width-1:0] out_next_router_address,
   output logic [lar_info_width-1:0]    out_lar_info
);

   localparam int dim_addr_width = clogb(num_routers_per_dim);
   localparam int node_addr_width = clogb(num_nodes_per_router);
   localparam int rc_idx_width = clogb(num_resource_classes);
   localparam int num_neighbors = neighbors_per_dim(connectivity, num_routers_per_dim);
   localparam int eject_base = num_dimensions * num_neighbors;
   localparam logic [dim_addr_width:0] k_ext = (dim_addr_width + 1)'(num_routers_per_dim);

   logic                         s1_valid;
   logic                         s1_advance;
   logic                         s2_advance;
   logic [router_addr_width-1:0] hop_addr;
   logic [router_addr_width-1:0] s1_next_addr;
   logic [dest_info_width-1:0]   s1_dest_info;
   logic [lar_info_width-1:0]    s1_lar_info;
   logic [lar_info_width-1:0]    route_lar_info;

   assign s2_advance = !out_valid || out_ready;
   assign s1_advance = !s1_valid || s2_advance;
   assign in_ready   = !s1_valid || s1_advance;

   rtr_next_hop_addr #(
      .num_routers_per_dim(num_routers_per_dim),
      .num_dimensions(num_dimensions),
      .connectivity(connectivity),
      .port_idx_width(port_idx_width)
   ) u_next_hop (
      .router_address(router_address),
      .port_idx(in_lar_info[lar_info_width-1 -: port_idx_width]),
      .next_router_address(hop_addr)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid     <= 1'b0;
         s1_next_addr <= '0;
         s1_dest_info <= '0;
         s1_lar_info  <= '0;
      end else if (s1_advance) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_next_addr <= hop_addr;
            s1_dest_info <= in_dest_info;
            s1_lar_info  <= in_lar_info;
         end
      end
   end

   generate
      if (routing_type == ROUTING_TYPE_PHASED_DOR) begin : g_phased_dor
         logic [port_idx_width-1:0]    eject_port;
         logic [port_idx_width-1:0]    dor_port;
         logic [rc_idx_width-1:0]      cur_rc;
         logic [rc_idx_width-1:0]      sel_rc;
         logic [router_addr_width-1:0] class_dest;
         logic [router_addr_width-1:0] sel_dest;
         logic [dim_addr_width-1:0]    cur_digit;
         logic [dim_addr_width-1:0]    dst_digit;
         logic [dim_addr_width:0]      delta;
         logic [dim_addr_width:0]      twice_delta;
         logic                         class_found;
         logic                         dim_found;
         logic                         in_eject;

         assign cur_rc   = s1_lar_info[rc_idx_width-1:0];
         assign in_eject = int'(s1_lar_info[lar_info_width-1 -: port_idx_width]) >= eject_base;

         if (node_addr_width > 0) begin : g_node
            assign eject_port = port_idx_width'(eject_base)
                              + port_idx_width'(s1_dest_info[node_addr_width-1:0]);
         end else begin : g_no_node
            assign eject_port = port_idx_width'(eject_base);
         end

         // Class 0 sits in the top bits of dest_info; the node address is in the bottom bits.
         always_comb begin
            route_lar_info = s1_lar_info;
            class_found = 1'b0;
            sel_rc = '0;
            sel_dest = '0;
            class_dest = '0;
            for (int c = 0; c < num_resource_classes; c++) begin
               class_dest = s1_dest_info[dest_info_width-1-c*router_addr_width -: router_addr_width];
               if (!class_found && c >= int'(cur_rc) && class_dest != s1_next_addr) begin
                  class_found = 1'b1;
                  sel_rc = rc_idx_width'(c);
                  sel_dest = class_dest;
               end
            end
            dim_found = 1'b0;
            dor_port = '0;
            cur_digit = '0;
            dst_digit = '0;
            delta = '0;
            twice_delta = '0;
            for (int d = 0; d < num_dimensions; d++) begin
               cur_digit = s1_next_addr[(num_dimensions-1-d)*dim_addr_width +: dim_addr_width];
               dst_digit = sel_dest[(num_dimensions-1-d)*dim_addr_width +: dim_addr_width];
               if (!dim_found && cur_digit != dst_digit) begin
                  dim_found = 1'b1;
                  delta = {1'b0, dst_digit} + k_ext - {1'b0, cur_digit};
                  if (delta >= k_ext) delta = delta - k_ext;
                  twice_delta = delta << 1;
                  if (connectivity == CONNECTIVITY_FULL)
                     dor_port = port_idx_width'(d * (num_routers_per_dim - 1) + int'(delta) - 1);
                  else if (connectivity == CONNECTIVITY_RING)
                     dor_port = port_idx_width'(2 * d + ((twice_delta <= k_ext) ? 1 : 0));
                  else
                     dor_port = port_idx_width'(2 * d + ((dst_digit < cur_digit) ? 0 : 1));
               end
            end
            if (in_eject)
               route_lar_info = s1_lar_info;
            else if (!class_found)
               route_lar_info = {eject_port, rc_idx_width'(num_resource_classes - 1)};
            else
               route_lar_info = {dor_port, sel_rc};
         end
      end else begin : g_unsupported
         assign route_lar_info = '0;
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid               <= 1'b0;
         out_dest_info           <= '0;
         out_next_router_address <= '0;
         out_lar_info            <= '0;
      end else if (s2_advance) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_dest_info           <= s1_dest_info;
            out_next_router_address <= s1_next_addr;
            out_lar_info            <= route_lar_info;
         end
      end
   end

endmodule
